// File: rtl/tank_bullet.sv
// Player tank projectile: owns a single 4x4 bullet.
// A fire press arms a request. The next refresh_tick spawns the bullet at the
// barrel, and the bullet then moves once per refresh_tick along the direction
// that was latched at spawn. The bullet retires on a hit or when it leaves the
// screen, and a reload cooldown follows.
module tank_bullet #(
    parameter int SPEED          = 2,
    parameter int COOLDOWN_TICKS = 15,
    parameter int H_MAX          = 639,
    parameter int V_MAX          = 479,
    parameter int PARK           = 1023
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       refresh_tick,
    input  logic       fire,
    input  logic [9:0] x_tank,
    input  logic [9:0] y_tank,
    input  logic [1:0] tank_dir,
    input  logic       hit,
    output logic [9:0] x_tank_bullet,
    output logic [9:0] y_tank_bullet,
    output logic       bullet_on,
    output logic       bullet_active,
    output logic       bullet_fired
);

    localparam logic [9:0]        PARK_POS = 10'(PARK);
    localparam logic [7:0]        CD_LAST  = 8'(COOLDOWN_TICKS);
    localparam logic signed [11:0] H_LIM   = 12'(H_MAX);
    localparam logic signed [11:0] V_LIM   = 12'(V_MAX);
    localparam logic signed [11:0] STEP    = 12'(SPEED);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLY      = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    // A bullet top-left coordinate is unusable if it is negative or if its
    // far edge (pos+3) falls beyond the last visible line.
    function automatic logic off_screen(input logic signed [11:0] pos,
                                        input logic signed [11:0] lim);
        return (pos < 12'sd0) || ((pos + 12'sd3) > lim);
    endfunction

    state_t      state_q;
    logic [9:0]  x_q, y_q;
    logic [1:0]  dir_q;
    logic [7:0]  cnt_q;
    logic        fired_q;
    logic        fire_req_q;
    logic        fire_s1_q, fire_s2_q, fire_s3_q;
    logic [2:0]  sync_vld_q;
    logic        fire_edge;

    logic signed [11:0] xt_d, yt_d, sx_d, sy_d, xb_d, yb_d, mx_d, my_d;
    logic               spawn_ok_d, move_ok_d;
    logic [7:0]         cnt_d;
    logic [10:0]        x_end, y_end;

    // Fire synchroniser and edge history. sync_vld_q marks when the history
    // holds real samples, so a button already held at reset release is not
    // mistaken for a new press.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            fire_s1_q  <= 1'b0;
            fire_s2_q  <= 1'b0;
            fire_s3_q  <= 1'b0;
            sync_vld_q <= 3'b000;
        end else begin
            fire_s1_q  <= fire;
            fire_s2_q  <= fire_s1_q;
            fire_s3_q  <= fire_s2_q;
            sync_vld_q <= {sync_vld_q[1:0], 1'b1};
        end
    end

    assign fire_edge = sync_vld_q[2] && fire_s2_q && !fire_s3_q;

    // Candidate spawn position at the barrel, and candidate next position in flight.
    always_comb begin
        xt_d = signed'({2'b00, x_tank});
        yt_d = signed'({2'b00, y_tank});
        sx_d = xt_d;
        sy_d = yt_d;
        unique case (tank_dir)
            2'd0: begin sx_d = xt_d + 12'sd14; sy_d = yt_d - 12'sd4;  end
            2'd1: begin sx_d = xt_d + 12'sd32; sy_d = yt_d + 12'sd14; end
            2'd2: begin sx_d = xt_d + 12'sd14; sy_d = yt_d + 12'sd32; end
            2'd3: begin sx_d = xt_d - 12'sd4;  sy_d = yt_d + 12'sd14; end
        endcase
        spawn_ok_d = !off_screen(sx_d, H_LIM) && !off_screen(sy_d, V_LIM);

        xb_d = signed'({2'b00, x_q});
        yb_d = signed'({2'b00, y_q});
        mx_d = xb_d;
        my_d = yb_d;
        unique case (dir_q)
            2'd0: my_d = yb_d - STEP;
            2'd1: mx_d = xb_d + STEP;
            2'd2: my_d = yb_d + STEP;
            2'd3: mx_d = xb_d - STEP;
        endcase
        move_ok_d = !off_screen(mx_d, H_LIM) && !off_screen(my_d, V_LIM);

        cnt_d = cnt_q + 8'd1;
    end

    // Bullet FSM with registered position, direction, cooldown and fire pulse.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            x_q        <= PARK_POS;
            y_q        <= PARK_POS;
            dir_q      <= 2'd0;
            cnt_q      <= 8'd0;
            fired_q    <= 1'b0;
            fire_req_q <= 1'b0;
        end else begin
            fired_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (refresh_tick) begin
                        // The tick consumes any pending request; a press in
                        // this same cycle arms the next tick.
                        fire_req_q <= fire_edge;
                        if (fire_req_q && spawn_ok_d) begin
                            x_q        <= sx_d[9:0];
                            y_q        <= sy_d[9:0];
                            dir_q      <= tank_dir;
                            fired_q    <= 1'b1;
                            fire_req_q <= 1'b0;
                            state_q    <= FLY;
                        end
                    end else if (fire_edge) begin
                        fire_req_q <= 1'b1;
                    end
                end
                FLY: begin
                    fire_req_q <= 1'b0;
                    if (hit || (refresh_tick && !move_ok_d)) begin
                        x_q     <= PARK_POS;
                        y_q     <= PARK_POS;
                        cnt_q   <= 8'd0;
                        state_q <= COOLDOWN;
                    end else if (refresh_tick) begin
                        x_q <= mx_d[9:0];
                        y_q <= my_d[9:0];
                    end
                end
                COOLDOWN: begin
                    fire_req_q <= 1'b0;
                    if (refresh_tick) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == CD_LAST) begin
                            state_q    <= IDLE;
                            fire_req_q <= fire_edge;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    x_q        <= PARK_POS;
                    y_q        <= PARK_POS;
                    fire_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Pixel-inside-bullet test against the registered position.
    always_comb begin
        x_end     = {1'b0, x_q} + 11'd3;
        y_end     = {1'b0, y_q} + 11'd3;
        bullet_on = (state_q == FLY)
                    && (x >= x_q) && ({1'b0, x} <= x_end)
                    && (y >= y_q) && ({1'b0, y} <= y_end);
    end

    assign x_tank_bullet = x_q;
    assign y_tank_bullet = y_q;
    assign bullet_active = (state_q == FLY);
    assign bullet_fired  = fired_q;

endmodule

// File: tb/tb_tank_bullet.sv
// Directed bench for tank_bullet: spawn, direction latch, screen exit with
// cooldown, hit priority, spawn rejection and asynchronous reset.
module tb_tank_bullet;

    logic       clk_50MHz;
    logic       reset;
    logic [9:0] x, y;
    logic       refresh_tick;
    logic       fire;
    logic [9:0] x_tank, y_tank;
    logic [1:0] tank_dir;
    logic       hit;
    logic [9:0] x_tank_bullet, y_tank_bullet;
    logic       bullet_on, bullet_active, bullet_fired;

    int checks = 0;
    int errors = 0;

    tank_bullet dut (
        .clk_50MHz     (clk_50MHz),
        .reset         (reset),
        .x             (x),
        .y             (y),
        .refresh_tick  (refresh_tick),
        .fire          (fire),
        .x_tank        (x_tank),
        .y_tank        (y_tank),
        .tank_dir      (tank_dir),
        .hit           (hit),
        .x_tank_bullet (x_tank_bullet),
        .y_tank_bullet (y_tank_bullet),
        .bullet_on     (bullet_on),
        .bullet_active (bullet_active),
        .bullet_fired  (bullet_fired)
    );

    initial clk_50MHz = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    task automatic tick();
        @(negedge clk_50MHz) refresh_tick = 1'b1;
        @(negedge clk_50MHz) refresh_tick = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_fire();
        @(negedge clk_50MHz) fire = 1'b1;
        repeat (4) @(negedge clk_50MHz);
        fire = 1'b0;
        repeat (3) @(negedge clk_50MHz);
    endtask

    task automatic pulse_hit();
        @(negedge clk_50MHz) hit = 1'b1;
        @(negedge clk_50MHz) hit = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk_50MHz);
        checks++;
        if (x_tank_bullet !== 10'd1023 || y_tank_bullet !== 10'd1023) begin
            errors++;
            $display("FAIL reset_pos got (%0d,%0d) want (1023,1023)", x_tank_bullet, y_tank_bullet);
        end
        checks++;
        if (bullet_active !== 1'b0 || bullet_fired !== 1'b0 || bullet_on !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got act=%b fired=%b on=%b want 0,0,0", bullet_active, bullet_fired, bullet_on);
        end
        reset = 1'b1;
        repeat (5) @(negedge clk_50MHz);
    endtask

    task automatic test_spawn_up();
        x_tank = 10'd300; y_tank = 10'd200; tank_dir = 2'd0;
        press_fire();
        tick();
        checks++;
        if (x_tank_bullet !== 10'd314 || y_tank_bullet !== 10'd196) begin
            errors++;
            $display("FAIL spawn_up_pos got (%0d,%0d) want (314,196)", x_tank_bullet, y_tank_bullet);
        end
        checks++;
        if (bullet_fired !== 1'b1 || bullet_active !== 1'b1) begin
            errors++;
            $display("FAIL spawn_up_flags got fired=%b act=%b want 1,1", bullet_fired, bullet_active);
        end
        x = 10'd317; y = 10'd199;
        @(negedge clk_50MHz);
        checks++;
        if (bullet_fired !== 1'b0) begin
            errors++;
            $display("FAIL fired_one_cycle got %b want 0", bullet_fired);
        end
        checks++;
        if (bullet_on !== 1'b1) begin
            errors++;
            $display("FAIL bullet_on_inside got %b want 1", bullet_on);
        end
        x = 10'd318;
        #1;
        checks++;
        if (bullet_on !== 1'b0) begin
            errors++;
            $display("FAIL bullet_on_outside got %b want 0", bullet_on);
        end
        x = 10'd0; y = 10'd0;
        tick_n(3);
        checks++;
        if (x_tank_bullet !== 10'd314 || y_tank_bullet !== 10'd190) begin
            errors++;
            $display("FAIL move_up got (%0d,%0d) want (314,190)", x_tank_bullet, y_tank_bullet);
        end
    endtask

    task automatic test_hit_priority();
        @(negedge clk_50MHz);
        hit = 1'b1; refresh_tick = 1'b1;
        @(negedge clk_50MHz);
        hit = 1'b0; refresh_tick = 1'b0;
        checks++;
        if (x_tank_bullet !== 10'd1023 || y_tank_bullet !== 10'd1023 || bullet_active !== 1'b0) begin
            errors++;
            $display("FAIL hit_priority got (%0d,%0d) act=%b want (1023,1023) act=0", x_tank_bullet, y_tank_bullet, bullet_active);
        end
        tick_n(15);
    endtask

    task automatic test_dir_latch();
        x_tank = 10'd100; y_tank = 10'd100; tank_dir = 2'd1;
        press_fire();
        tick();
        checks++;
        if (x_tank_bullet !== 10'd132 || y_tank_bullet !== 10'd114) begin
            errors++;
            $display("FAIL spawn_right got (%0d,%0d) want (132,114)", x_tank_bullet, y_tank_bullet);
        end
        tank_dir = 2'd3;
        tick_n(2);
        checks++;
        if (x_tank_bullet !== 10'd136 || y_tank_bullet !== 10'd114) begin
            errors++;
            $display("FAIL dir_latch got (%0d,%0d) want (136,114)", x_tank_bullet, y_tank_bullet);
        end
        pulse_hit();
        checks++;
        if (x_tank_bullet !== 10'd1023 || bullet_active !== 1'b0) begin
            errors++;
            $display("FAIL hit_no_tick got x=%0d act=%b want 1023,0", x_tank_bullet, bullet_active);
        end
        tick_n(15);
    endtask

    task automatic test_screen_exit();
        x_tank = 10'd9; y_tank = 10'd100; tank_dir = 2'd3;
        press_fire();
        tick();
        checks++;
        if (x_tank_bullet !== 10'd5 || y_tank_bullet !== 10'd114) begin
            errors++;
            $display("FAIL spawn_left got (%0d,%0d) want (5,114)", x_tank_bullet, y_tank_bullet);
        end
        tick_n(2);
        checks++;
        if (x_tank_bullet !== 10'd1) begin
            errors++;
            $display("FAIL left_to_1 got %0d want 1", x_tank_bullet);
        end
        tick();
        checks++;
        if (x_tank_bullet !== 10'd1023 || y_tank_bullet !== 10'd1023 || bullet_active !== 1'b0) begin
            errors++;
            $display("FAIL exit_left got (%0d,%0d) act=%b want (1023,1023) act=0", x_tank_bullet, y_tank_bullet, bullet_active);
        end
        press_fire();
        tick_n(14);
        checks++;
        if (x_tank_bullet !== 10'd1023 || bullet_active !== 1'b0) begin
            errors++;
            $display("FAIL cooldown_14 got x=%0d act=%b want 1023,0", x_tank_bullet, bullet_active);
        end
        tick_n(2);
        checks++;
        if (x_tank_bullet !== 10'd1023 || bullet_active !== 1'b0) begin
            errors++;
            $display("FAIL cooldown_edge_dropped got x=%0d act=%b want 1023,0", x_tank_bullet, bullet_active);
        end
        press_fire();
        tick();
        checks++;
        if (x_tank_bullet !== 10'd5 || bullet_active !== 1'b1 || bullet_fired !== 1'b1) begin
            errors++;
            $display("FAIL respawn got x=%0d act=%b fired=%b want 5,1,1", x_tank_bullet, bullet_active, bullet_fired);
        end
        pulse_hit();
        tick_n(15);
    endtask

    task automatic test_right_edge();
        x_tank = 10'd604; y_tank = 10'd100; tank_dir = 2'd1;
        press_fire();
        tick();
        checks++;
        if (x_tank_bullet !== 10'd636 || bullet_active !== 1'b1) begin
            errors++;
            $display("FAIL spawn_at_edge got x=%0d act=%b want 636,1", x_tank_bullet, bullet_active);
        end
        tick();
        checks++;
        if (x_tank_bullet !== 10'd1023 || bullet_active !== 1'b0) begin
            errors++;
            $display("FAIL exit_right got x=%0d act=%b want 1023,0", x_tank_bullet, bullet_active);
        end
        tick_n(15);
    endtask

    task automatic test_spawn_reject();
        x_tank = 10'd300; y_tank = 10'd2; tank_dir = 2'd0;
        press_fire();
        tick();
        checks++;
        if (x_tank_bullet !== 10'd1023 || y_tank_bullet !== 10'd1023 || bullet_active !== 1'b0 || bullet_fired !== 1'b0) begin
            errors++;
            $display("FAIL reject got (%0d,%0d) act=%b fired=%b want (1023,1023) 0,0", x_tank_bullet, y_tank_bullet, bullet_active, bullet_fired);
        end
        y_tank = 10'd200;
        tick();
        checks++;
        if (x_tank_bullet !== 10'd1023 || bullet_active !== 1'b0) begin
            errors++;
            $display("FAIL req_cleared got x=%0d act=%b want 1023,0", x_tank_bullet, bullet_active);
        end
    endtask

    task automatic test_async_reset();
        x_tank = 10'd300; y_tank = 10'd200; tank_dir = 2'd0;
        press_fire();
        tick();
        checks++;
        if (bullet_active !== 1'b1 || y_tank_bullet !== 10'd196) begin
            errors++;
            $display("FAIL pre_reset_flight got act=%b y=%0d want 1,196", bullet_active, y_tank_bullet);
        end
        @(posedge clk_50MHz);
        #5 reset = 1'b0;
        fire = 1'b1;
        #1;
        checks++;
        if (x_tank_bullet !== 10'd1023 || y_tank_bullet !== 10'd1023 || bullet_active !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got (%0d,%0d) act=%b want (1023,1023) act=0", x_tank_bullet, y_tank_bullet, bullet_active);
        end
        repeat (2) @(negedge clk_50MHz);
        reset = 1'b1;
        repeat (6) @(negedge clk_50MHz);
        tick_n(3);
        checks++;
        if (x_tank_bullet !== 10'd1023 || bullet_active !== 1'b0 || bullet_fired !== 1'b0) begin
            errors++;
            $display("FAIL held_fire_no_spawn got x=%0d act=%b fired=%b want 1023,0,0", x_tank_bullet, bullet_active, bullet_fired);
        end
        fire = 1'b0;
    endtask

    initial begin
        reset = 1'b0; x = 10'd0; y = 10'd0; refresh_tick = 1'b0; fire = 1'b0;
        x_tank = 10'd0; y_tank = 10'd0; tank_dir = 2'd0; hit = 1'b0;
        test_reset();
        test_spawn_up();
        test_hit_priority();
        test_dir_latch();
        test_screen_exit();
        test_right_edge();
        test_spawn_reject();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
